// File: rtl/camera_capture_pkg.sv
// Shared definitions for the camera capture path: capture FSM states,
// default frame geometry and the pixel-address width shared with the
// display side of the frame buffer.
package camera_capture_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_CFG = 2'd0,
        ST_SKIP     = 2'd1,
        ST_WAIT_VS  = 2'd2,
        ST_ACTIVE   = 2'd3
    } cap_state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int PIX_CNT_W    = 19;
    localparam int PIXEL_W      = 12;

    // Frame-buffer pixel layout: blue in the top nibble, red in the bottom.
    function automatic logic [PIXEL_W-1:0] pack_bgr(input logic [3:0] b,
                                                    input logic [3:0] g,
                                                    input logic [3:0] r);
        return {b, g, r};
    endfunction

endpackage

// File: rtl/cam_byte_pack.sv
// Two-bytes-per-pixel assembler: the first byte of each pair carries red,
// the second carries green and blue. Produces one write strobe per
// completed pair and reports odd-length lines and frame overruns.
module cam_byte_pack
    import camera_capture_pkg::*;
(
    input  logic               i_p_clk,
    input  logic               i_rstn,
    input  logic               i_en,
    input  logic               i_href,
    input  logic [7:0]         i_data,
    input  logic               i_full,
    output logic               o_wr_en,
    output logic [PIXEL_W-1:0] o_wdata,
    output logic               o_phase,
    output logic               o_odd_err,
    output logic               o_ovf_err
);

    logic       r_phase;
    logic [3:0] r_red;

    // Byte phase, red latch and registered pixel/strobe; idle clears the phase.
    always_ff @(posedge i_p_clk) begin
        if (!i_rstn) begin
            r_phase <= 1'b0;
            r_red   <= 4'd0;
            o_wr_en <= 1'b0;
            o_wdata <= '0;
        end else begin
            o_wr_en <= 1'b0;
            if (!i_en || !i_href) begin
                r_phase <= 1'b0;
            end else if (!r_phase) begin
                r_red   <= i_data[3:0];
                r_phase <= 1'b1;
            end else begin
                r_phase <= 1'b0;
                if (!i_full) begin
                    o_wr_en <= 1'b1;
                    o_wdata <= pack_bgr(i_data[3:0], i_data[7:4], r_red);
                end
            end
        end
    end

    assign o_phase   = r_phase;
    // Line ended halfway through a pixel: the lone red byte is discarded.
    assign o_odd_err = i_en && !i_href && r_phase;
    // A pixel completed after the frame buffer is already full.
    assign o_ovf_err = i_en && i_href && r_phase && i_full;

endmodule

// File: rtl/camera_capture.sv
// Camera capture front end: registers the camera bus, discards the first
// frames after configuration, then writes each frame into the frame buffer
// as 12-bit pixels with a linear address, flagging size/protocol errors.
module camera_capture
    import camera_capture_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int SKIP_FRAMES = 2
) (
    input  logic                 i_p_clk,
    input  logic                 i_rstn,
    input  logic                 i_cfg_done,
    input  logic                 i_vsync,
    input  logic                 i_href,
    input  logic [7:0]           i_data,
    output logic                 o_wr_en,
    output logic [PIX_CNT_W-1:0] o_waddr,
    output logic [PIXEL_W-1:0]   o_wdata,
    output logic                 o_frame_done,
    output logic                 o_frame_err
);

    localparam int                   TOTAL     = H_ACTIVE * V_ACTIVE;
    localparam logic [PIX_CNT_W-1:0] PIX_TOTAL = PIX_CNT_W'(TOTAL);
    localparam logic [PIX_CNT_W-1:0] ADDR_MAX  = PIX_CNT_W'(TOTAL - 1);
    localparam logic [7:0]           SKIP_N    = 8'(SKIP_FRAMES);

    logic                 r_vs_q;
    logic                 r_hr_q;
    logic [7:0]           r_d_q;
    logic                 r_vs_prev;
    logic                 r_prime0;
    logic                 r_prime1;
    cap_state_t           r_state;
    cap_state_t           w_state_nxt;
    logic [7:0]           r_skip_cnt;
    logic [PIX_CNT_W-1:0] r_pix_cnt;

    logic                 w_vs_rise;
    logic                 w_vs_fall;
    logic                 w_skip_last;
    logic                 w_pack_en;
    logic                 w_full;
    logic                 w_phase;
    logic                 w_odd_err;
    logic                 w_ovf_err;
    logic                 w_enter_active;
    logic                 w_err_evt;
    logic [PIX_CNT_W:0]   w_final_cnt;

    // Single register stage on the camera bus; the prime bits keep the
    // post-reset fill of the VSYNC history from looking like an edge.
    always_ff @(posedge i_p_clk) begin
        if (!i_rstn) begin
            r_vs_q    <= 1'b0;
            r_hr_q    <= 1'b0;
            r_d_q     <= 8'd0;
            r_vs_prev <= 1'b0;
            r_prime0  <= 1'b0;
            r_prime1  <= 1'b0;
        end else begin
            r_vs_q    <= i_vsync;
            r_hr_q    <= i_href;
            r_d_q     <= i_data;
            r_vs_prev <= r_vs_q;
            r_prime0  <= 1'b1;
            r_prime1  <= r_prime0;
        end
    end

    assign w_vs_rise      = r_prime1 && r_vs_q && !r_vs_prev;
    assign w_vs_fall      = r_prime1 && !r_vs_q && r_vs_prev;
    assign w_skip_last    = w_vs_rise && (({1'b0, r_skip_cnt} + 9'd1) == {1'b0, SKIP_N});
    assign w_pack_en      = (r_state == ST_ACTIVE) && i_cfg_done && !w_vs_rise;
    assign w_full         = (r_pix_cnt == PIX_TOTAL);
    assign w_final_cnt    = {1'b0, r_pix_cnt} + {{PIX_CNT_W{1'b0}}, o_wr_en};
    assign w_enter_active = (r_state == ST_WAIT_VS) && (w_state_nxt == ST_ACTIVE);

    // Next-state decode; losing configuration always forces a restart.
    always_comb begin
        w_state_nxt = r_state;
        if (!i_cfg_done) begin
            w_state_nxt = ST_WAIT_CFG;
        end else begin
            case (r_state)
                ST_WAIT_CFG: w_state_nxt = (SKIP_FRAMES == 0) ? ST_WAIT_VS : ST_SKIP;
                ST_SKIP:     if (w_skip_last) w_state_nxt = ST_WAIT_VS;
                ST_WAIT_VS:  if (w_vs_fall) w_state_nxt = ST_ACTIVE;
                ST_ACTIVE:   if (w_vs_rise) w_state_nxt = ST_WAIT_VS;
                default:     w_state_nxt = ST_WAIT_CFG;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge i_p_clk) begin
        if (!i_rstn) r_state <= ST_WAIT_CFG;
        else         r_state <= w_state_nxt;
    end

    // Count VSYNC rising edges while discarding start-up frames.
    always_ff @(posedge i_p_clk) begin
        if (!i_rstn || r_state != ST_SKIP) r_skip_cnt <= 8'd0;
        else if (w_vs_rise)                r_skip_cnt <= r_skip_cnt + 8'd1;
    end

    cam_byte_pack u_pack (
        .i_p_clk   (i_p_clk),
        .i_rstn    (i_rstn),
        .i_en      (w_pack_en),
        .i_href    (r_hr_q),
        .i_data    (r_d_q),
        .i_full    (w_full),
        .o_wr_en   (o_wr_en),
        .o_wdata   (o_wdata),
        .o_phase   (w_phase),
        .o_odd_err (w_odd_err),
        .o_ovf_err (w_ovf_err)
    );

    // Write address and written-pixel count; address saturates at the last pixel.
    always_ff @(posedge i_p_clk) begin
        if (!i_rstn || w_enter_active) begin
            o_waddr   <= '0;
            r_pix_cnt <= '0;
        end else if (o_wr_en) begin
            r_pix_cnt <= r_pix_cnt + 1'b1;
            if (o_waddr != ADDR_MAX) o_waddr <= o_waddr + 1'b1;
        end
    end

    assign w_err_evt = (r_state == ST_ACTIVE) &&
                       (w_odd_err || w_ovf_err ||
                        (w_vs_rise && (r_hr_q || w_phase ||
                                       w_final_cnt != {1'b0, PIX_TOTAL})));

    // End-of-frame pulse and sticky error flag.
    always_ff @(posedge i_p_clk) begin
        if (!i_rstn) begin
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_frame_done <= (r_state == ST_ACTIVE) && w_vs_rise;
            if (w_err_evt) o_frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_camera_capture.sv
module tb_camera_capture;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int SKIP  = 2;
    localparam int TOTAL = H * V;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_done;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        wr_en;
    logic [18:0] waddr;
    logic [11:0] wdata;
    logic        frame_done;
    logic        frame_err;

    camera_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(SKIP)) dut (
        .i_p_clk      (clk),
        .i_rstn       (rstn),
        .i_cfg_done   (cfg_done),
        .i_vsync      (vsync),
        .i_href       (href),
        .i_data       (data),
        .o_wr_en      (wr_en),
        .o_waddr      (waddr),
        .o_wdata      (wdata),
        .o_frame_done (frame_done),
        .o_frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed writes, recorded away from the active edge.
    logic [18:0] cap_addr[$];
    logic [11:0] cap_data[$];
    int          cap_cyc[$];

    always @(negedge clk) begin
        if (rstn === 1'b1 && wr_en === 1'b1) begin
            cap_addr.push_back(waddr);
            cap_data.push_back(wdata);
            cap_cyc.push_back(cyc);
        end
        if (rstn === 1'b1 && frame_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Reference model results for the most recent frame sent.
    logic [18:0] exp_addr[$];
    logic [11:0] exp_data[$];
    logic        exp_err;
    int          exp_waddr;
    int          t_b1;
    logic        err_before_odd;
    logic        err_after_odd;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cap();
        cap_addr.delete();
        cap_data.delete();
        cap_cyc.delete();
    endtask

    // Drives one camera frame and computes, from the pixel format rules,
    // which frame-buffer writes a capturing receiver must make.
    task automatic send_frame(input int nlines, input int odd_line, input bit fixed_first);
        int          p;
        int          len;
        int          nw;
        logic [7:0]  b;
        logic [7:0]  prev;
        exp_addr.delete();
        exp_data.delete();
        exp_err = 1'b0;
        p = 0;
        prev = 8'h00;
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (3) tick();
        for (int l = 0; l < nlines; l++) begin
            len = (l == odd_line) ? 2 * H - 1 : 2 * H;
            if (l == odd_line) err_before_odd = frame_err;
            for (int k = 0; k < len; k++) begin
                if (fixed_first && l == 0 && k < 2) b = (k == 0) ? 8'h0A : 8'h5C;
                else                                b = 8'($urandom_range(0, 255));
                href = 1'b1;
                data = b;
                if (l == 0 && k == 1) t_b1 = cyc;
                if (k % 2 == 1) begin
                    if (p < TOTAL) begin
                        exp_addr.push_back(19'(p));
                        exp_data.push_back({b[3:0], b[7:4], prev[3:0]});
                    end else begin
                        exp_err = 1'b1;
                    end
                    p++;
                end else begin
                    prev = b;
                end
                tick();
            end
            href = 1'b0;
            data = 8'($urandom_range(0, 255));
            if (len % 2 == 1) exp_err = 1'b1;
            repeat (3) tick();
            if (l == odd_line) err_after_odd = frame_err;
        end
        if (p != TOTAL) exp_err = 1'b1;
        nw = (p < TOTAL) ? p : TOTAL;
        exp_waddr = (nw >= TOTAL) ? TOTAL - 1 : nw;
        vsync = 1'b1;
        repeat (4) tick();
    endtask

    task automatic do_reset_and_sync();
        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        repeat (2) tick();
        clear_cap();
        send_frame(V, -1, 1'b0);
        send_frame(V, -1, 1'b0);
        n_checks++;
        if (cap_addr.size() != 0) begin
            n_fail++;
            $display("FAIL sync_skip: writes=%0d required=0", cap_addr.size());
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; cfg_done = 1'b0; vsync = 1'b1; href = 1'b0; data = 8'h00;
        repeat (3) tick();
        n_checks++; if (wr_en !== 1'b0)      begin n_fail++; $display("FAIL reset_wr_en: got=%b want=0", wr_en); end
        n_checks++; if (waddr !== 19'd0)     begin n_fail++; $display("FAIL reset_waddr: got=%0d want=0", waddr); end
        n_checks++; if (wdata !== 12'd0)     begin n_fail++; $display("FAIL reset_wdata: got=%h want=000", wdata); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got=%b want=0", frame_done); end
        n_checks++; if (frame_err !== 1'b0)  begin n_fail++; $display("FAIL reset_err: got=%b want=0", frame_err); end
        rstn = 1'b1;
        tick();
        cfg_done = 1'b1;
        tick();
    endtask

    task automatic test_skip_and_capture();
        int d0;
        d0 = done_cnt;
        for (int f = 0; f < SKIP; f++) begin
            clear_cap();
            send_frame(V, -1, 1'b0);
            n_checks++;
            if (cap_addr.size() != 0) begin
                n_fail++;
                $display("FAIL skip_frame%0d: writes=%0d required=0", f + 1, cap_addr.size());
            end
        end
        n_checks++;
        if (done_cnt != d0) begin n_fail++; $display("FAIL skip_done: pulses=%0d required=0", done_cnt - d0); end
        clear_cap();
        send_frame(V, -1, 1'b0);
        n_checks++;
        if (cap_addr.size() != exp_addr.size()) begin
            n_fail++;
            $display("FAIL cap_count: writes=%0d required=%0d", cap_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
            n_checks++;
            if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
                n_fail++;
                $display("FAIL cap_pixel%0d: got=%0d/%h want=%0d/%h", i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_checks++;
        if (int'(waddr) != exp_waddr) begin n_fail++; $display("FAIL cap_last_addr: got=%0d want=%0d", waddr, exp_waddr); end
        n_checks++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL cap_done: pulses=%0d required=1", done_cnt - d0); end
        n_checks++;
        if (frame_err !== exp_err) begin n_fail++; $display("FAIL cap_err: got=%b want=%b", frame_err, exp_err); end
    endtask

    task automatic test_pixel_latency();
        clear_cap();
        send_frame(V, -1, 1'b1);
        n_checks++;
        if (cap_addr.size() == 0) begin
            n_fail++;
            $display("FAIL lat_nowrite: writes=0 required=%0d", TOTAL);
        end else begin
            n_checks++;
            if (cap_cyc[0] - t_b1 != 2) begin n_fail++; $display("FAIL lat_cycles: got=%0d want=2", cap_cyc[0] - t_b1); end
            n_checks++;
            if (cap_data[0] !== 12'hC5A) begin n_fail++; $display("FAIL lat_data: got=%h want=c5a", cap_data[0]); end
            n_checks++;
            if (cap_addr[0] !== 19'd0) begin n_fail++; $display("FAIL lat_addr: got=%0d want=0", cap_addr[0]); end
        end
        n_checks++;
        if (cap_addr.size() != exp_addr.size()) begin
            n_fail++;
            $display("FAIL lat_count: writes=%0d required=%0d", cap_addr.size(), exp_addr.size());
        end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL lat_err: got=%b want=0", frame_err); end
    endtask

    task automatic test_odd_line();
        int first_line_writes;
        clear_cap();
        send_frame(V, 1, 1'b0);
        n_checks++;
        if (err_before_odd !== 1'b0) begin n_fail++; $display("FAIL odd_err_before: got=%b want=0", err_before_odd); end
        n_checks++;
        if (err_after_odd !== 1'b1) begin n_fail++; $display("FAIL odd_err_after: got=%b want=1", err_after_odd); end
        first_line_writes = 0;
        foreach (cap_addr[i]) if (cap_addr[i] >= 19'(H) && cap_addr[i] < 19'(2 * H - 1)) first_line_writes++;
        n_checks++;
        if (cap_addr.size() != exp_addr.size() || first_line_writes != H - 1) begin
            n_fail++;
            $display("FAIL odd_count: writes=%0d line=%0d required=%0d line=%0d",
                     cap_addr.size(), first_line_writes, exp_addr.size(), H - 1);
        end
        for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
            n_checks++;
            if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
                n_fail++;
                $display("FAIL odd_pixel%0d: got=%0d/%h want=%0d/%h", i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset_and_sync();
        clear_cap();
        send_frame(V + 1, -1, 1'b0);
        n_checks++;
        if (cap_addr.size() != TOTAL) begin n_fail++; $display("FAIL ovf_count: writes=%0d required=%0d", cap_addr.size(), TOTAL); end
        for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
            n_checks++;
            if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
                n_fail++;
                $display("FAIL ovf_pixel%0d: got=%0d/%h want=%0d/%h", i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_checks++;
        if (waddr !== 19'(TOTAL - 1)) begin n_fail++; $display("FAIL ovf_addr_hold: got=%0d want=%0d", waddr, TOTAL - 1); end
        n_checks++;
        if (frame_err !== exp_err) begin n_fail++; $display("FAIL ovf_err: got=%b want=%b", frame_err, exp_err); end
    endtask

    // Interrupts a frame at address 10 by reset (mode 0) or loss of config (mode 1).
    task automatic test_interrupt(input bit drop_cfg);
        int snap;
        clear_cap();
        snap = 0;
        fork
            send_frame(V, -1, 1'b0);
            begin
                for (int i = 0; i < 3000; i++) begin
                    @(negedge clk);
                    if (waddr == 19'd10) break;
                end
                n_checks++;
                if (waddr !== 19'd10) begin
                    n_fail++;
                    $display("FAIL intr_timeout: waddr=%0d want=10", waddr);
                end
                @(posedge clk); #1;
                if (drop_cfg) cfg_done = 1'b0;
                else          rstn = 1'b0;
                tick();
                if (!drop_cfg) begin
                    n_checks++; if (wr_en !== 1'b0)     begin n_fail++; $display("FAIL rst_mid_wr_en: got=%b want=0", wr_en); end
                    n_checks++; if (waddr !== 19'd0)    begin n_fail++; $display("FAIL rst_mid_waddr: got=%0d want=0", waddr); end
                    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err: got=%b want=0", frame_err); end
                end
                snap = cap_addr.size();
                repeat (2) tick();
                cfg_done = 1'b1;
                rstn = 1'b1;
            end
        join
        send_frame(V, -1, 1'b0);
        n_checks++;
        if (cap_addr.size() != snap) begin
            n_fail++;
            $display("FAIL intr_no_write: writes=%0d required=0", cap_addr.size() - snap);
        end
        clear_cap();
        send_frame(V, -1, 1'b0);
        n_checks++;
        if (cap_addr.size() != exp_addr.size()) begin
            n_fail++;
            $display("FAIL intr_resume_count: writes=%0d required=%0d", cap_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
            n_checks++;
            if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
                n_fail++;
                $display("FAIL intr_pixel%0d: got=%0d/%h want=%0d/%h", i, cap_addr[i], cap_data[i], exp_addr[i], exp_data[i]);
            end
        end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL intr_err: got=%b want=0", frame_err); end
    endtask

    initial begin
        err_before_odd = 1'b0;
        err_after_odd  = 1'b0;
        t_b1 = 0;
        exp_err = 1'b0;
        exp_waddr = 0;
        test_reset();
        test_skip_and_capture();
        test_pixel_latency();
        test_odd_line();
        test_overflow();
        test_interrupt(1'b0);
        test_interrupt(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/camera_capture.md
CAMERA_CAPTURE -- requirements
Module: camera_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640, pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, lines per frame.
REQ-003 Parameter SKIP_FRAMES, default 2, whole frames discarded after config done.
REQ-004 i_p_clk  in  1  camera pixel clock (PCLK domain); all logic rising-edge.
REQ-005 i_rstn  in  1  reset, synchronous, active-low.
REQ-006 i_cfg_done  in  1  camera register configuration complete (level).
REQ-007 i_vsync  in  1  camera VSYNC, active-high, high between frames.
REQ-008 i_href  in  1  camera HREF, high while line bytes valid.
REQ-009 i_data  in  8  camera data byte.
REQ-010 o_wr_en  out  1  frame-buffer write strobe, one cycle per pixel.
REQ-011 o_waddr  out  19  frame-buffer write address, 0..H_ACTIVE*V_ACTIVE-1.
REQ-012 o_wdata  out  12  pixel {B[3:0],G[3:0],R[3:0]}.
REQ-013 o_frame_done  out  1  one-cycle pulse at end of each captured frame.
REQ-014 o_frame_err  out  1  sticky size/protocol error flag, cleared by reset only.

Function
REQ-015 i_vsync, i_href, i_data SHALL be registered once before any use; all timing below refers to the registered copies (vs_q, hr_q, d_q).
REQ-016 States: WAIT_CFG, SKIP, WAIT_VS, ACTIVE.
REQ-017 WAIT_CFG -> SKIP when i_cfg_done=1; skip counter loads 0.
REQ-018 SKIP: count vs_q rising edges; -> WAIT_VS when count reaches SKIP_FRAMES; SKIP_FRAMES=0 goes directly to WAIT_VS.
REQ-019 WAIT_VS -> ACTIVE on vs_q falling edge; o_waddr=0, byte phase=0 on entry.
REQ-020 ACTIVE: while hr_q=1, byte phase toggles each cycle; phase0 byte latched as R=d_q[3:0]; phase1 byte gives G=d_q[7:4], B=d_q[3:0].
REQ-021 o_wr_en SHALL pulse the cycle after a phase1 byte is on d_q (latency 2 cycles from pin); o_wdata valid with o_wr_en.
REQ-022 o_waddr SHALL increment by 1 the cycle after each o_wr_en; stays unchanged otherwise.
REQ-023 hr_q falling with phase=1 (odd byte count): partial pixel dropped, o_frame_err set, phase reset to 0.
REQ-024 Pixel beyond H_ACTIVE*V_ACTIVE-1 in a frame: write suppressed, address held at max, o_frame_err set; no wrap.
REQ-025 vs_q rising edge in ACTIVE: o_frame_done pulses next cycle; o_frame_err set if pixels written != H_ACTIVE*V_ACTIVE; -> WAIT_VS.
REQ-026 vs_q rising while hr_q=1: treated as frame end; pending partial pixel dropped and error flagged.
REQ-027 i_cfg_done deasserting in any state: -> WAIT_CFG next cycle, no further writes.
REQ-028 o_wr_en SHALL never assert outside ACTIVE.

Reset
REQ-029 On i_rstn=0: state WAIT_CFG; o_wr_en=0, o_waddr=0, o_wdata=0, o_frame_done=0, o_frame_err=0; phase, skip counter, input registers cleared.
REQ-030 Reset mid-frame SHALL abort immediately; capture resumes only after full SKIP sequence.

Structure
REQ-031 Shared package holds state enum, default frame dimensions, pixel-count width constant (19) shared with display_interface.
REQ-032 One sub-module natural: cam_byte_pack (phase toggle, R latch, 12-bit assembly, wr strobe).

Verification
REQ-033 cfg_done=1, 3 frames 640x480 bytes: frames 1-2 produce no o_wr_en; frame 3 gives 307200 writes, last o_waddr=307199, o_frame_done once, o_frame_err=0.
REQ-034 Bytes 0x0A,0x5C on one pixel -> o_wdata=0xC5A, o_wr_en exactly 2 cycles after second byte on pins.
REQ-035 Line of 1279 bytes -> 639 writes that line, o_frame_err=1 after href fall.
REQ-036 Frame with 481 lines -> writes stop at 307199, o_frame_err=1, o_waddr held 307199.
REQ-037 i_rstn low mid-line at address 1000 -> next cycle o_wr_en=0, o_waddr=0, state WAIT_CFG.
REQ-038 i_cfg_done dropped during ACTIVE -> no writes thereafter until cfg_done and 2 skipped frames.
